// File: rtl/adpll_ctrl.sv
// ADPLL loop controller: synchronised ref/fb phase detector, PI loop filter with a saturating
// integrator, and an IDLE/ACQUIRE/TRACK/LOCKED gain-scheduling state machine.
module adpll_ctrl #(
  parameter int unsigned CTRL_WIDTH = 5,
  parameter int unsigned ERR_WIDTH  = 8,
  parameter int unsigned BIAS       = 16,
  parameter int unsigned INT_WIDTH  = 12,
  parameter int unsigned INT_FRAC   = 4,
  parameter int unsigned KP_SH_ACQ  = 0,
  parameter int unsigned KI_SH_ACQ  = 1,
  parameter int unsigned KP_SH_TRK  = 1,
  parameter int unsigned KI_SH_TRK  = 3,
  parameter int unsigned LOCK_TOL   = 2,
  parameter int unsigned LOCK_COUNT = 16
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  ref_clk_i,
  input  logic                  fb_clk_i,
  output logic [CTRL_WIDTH-1:0] freq_sel_o,
  output logic [ERR_WIDTH-1:0]  error_o,
  output logic                  err_valid_o,
  output logic                  locked_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StTrack   = 2'd2,
    StLocked  = 2'd3
  } state_e;

  localparam int unsigned SumW = CTRL_WIDTH + INT_WIDTH;
  localparam int unsigned LcW  = $clog2(LOCK_COUNT + 1);
  localparam logic [ERR_WIDTH-2:0] CntMax = '1;

  state_e                 state_q, state_d;
  logic [2:0]             ref_sync_q, fb_sync_q;
  logic                   ref_pls_q, fb_pls_q;
  logic                   busy_q, busy_d, ref_lead_q, ref_lead_d;
  logic [ERR_WIDTH-2:0]   cnt_q, cnt_d;
  logic [ERR_WIDTH-1:0]   error_q, upd_err_q;
  logic                   valid_q, timeout_q, upd_q, upd_to_q;
  logic signed [INT_WIDTH-1:0] integ_q, integ_d;
  logic [CTRL_WIDTH-1:0]  freq_q, freq_d;
  logic [LcW-1:0]         lcnt_q, lcnt_d;

  logic                   run, emit, emit_to, stop;
  logic [ERR_WIDTH-1:0]   emit_mag, emit_err;

  assign run = enable_i && (state_q != StIdle);

  // Phase detector: count from the leading edge until the opposite edge arrives.
  always_comb begin
    busy_d     = busy_q;
    ref_lead_d = ref_lead_q;
    cnt_d      = cnt_q;
    emit       = 1'b0;
    emit_to    = 1'b0;
    emit_mag   = {1'b0, cnt_q};
    emit_err   = ref_lead_q ? emit_mag : -emit_mag;
    stop       = ref_lead_q ? fb_pls_q : ref_pls_q;
    if (!run) begin
      busy_d     = 1'b0;
      ref_lead_d = 1'b0;
      cnt_d      = '0;
    end else if (!busy_q) begin
      if (ref_pls_q && fb_pls_q) begin
        emit     = 1'b1;
        emit_err = '0;
      end else if (ref_pls_q || fb_pls_q) begin
        busy_d     = 1'b1;
        ref_lead_d = ref_pls_q;
        cnt_d      = 1;
      end
    end else if (stop || (cnt_q == CntMax)) begin
      emit    = 1'b1;
      emit_to = !stop;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  int unsigned                 ki_sh, kp_sh;
  logic [ERR_WIDTH-1:0]        err_ki, err_kp, err_abs;
  logic [INT_WIDTH-1:0]        integ_sh;
  logic [INT_WIDTH:0]          integ_sum;
  logic [SumW-1:0]             fsum;
  logic [LcW-1:0]              lcnt_inc;
  logic                        in_tol, reach;

  // Loop filter and mode state machine; LOCKED shares the tracking gains.
  always_comb begin
    ki_sh     = (state_q == StAcquire) ? KI_SH_ACQ : KI_SH_TRK;
    kp_sh     = (state_q == StAcquire) ? KP_SH_ACQ : KP_SH_TRK;
    err_ki    = $signed(error_q) >>> ki_sh;
    err_kp    = $signed(upd_err_q) >>> kp_sh;
    integ_sh  = integ_q >>> INT_FRAC;
    integ_sum = {integ_q[INT_WIDTH-1], integ_q}
              + {{(INT_WIDTH + 1 - ERR_WIDTH){err_ki[ERR_WIDTH-1]}}, err_ki};
    fsum      = SumW'(BIAS)
              - {{(SumW - ERR_WIDTH){err_kp[ERR_WIDTH-1]}}, err_kp}
              - {{(SumW - INT_WIDTH){integ_sh[INT_WIDTH-1]}}, integ_sh};
    err_abs   = upd_err_q[ERR_WIDTH-1] ? -upd_err_q : upd_err_q;
    in_tol    = (err_abs <= ERR_WIDTH'(LOCK_TOL)) && !upd_to_q;
    lcnt_inc  = lcnt_q + 1'b1;
    reach     = in_tol && (lcnt_inc == LcW'(LOCK_COUNT));

    state_d = state_q;
    integ_d = integ_q;
    freq_d  = freq_q;
    lcnt_d  = lcnt_q;
    if (!enable_i || (state_q == StIdle)) begin
      state_d = enable_i ? StAcquire : StIdle;
      integ_d = '0;
      freq_d  = CTRL_WIDTH'(BIAS);
      lcnt_d  = '0;
    end else begin
      if (valid_q) begin
        if (integ_sum[INT_WIDTH] != integ_sum[INT_WIDTH-1]) begin
          integ_d = integ_sum[INT_WIDTH] ? {1'b1, {(INT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(INT_WIDTH-1){1'b1}}};
        end else begin
          integ_d = integ_sum[INT_WIDTH-1:0];
        end
      end
      if (upd_q) begin
        if (fsum[SumW-1]) begin
          freq_d = '0;
        end else if (fsum[SumW-2:CTRL_WIDTH] != '0) begin
          freq_d = '1;
        end else begin
          freq_d = fsum[CTRL_WIDTH-1:0];
        end
        lcnt_d = in_tol ? lcnt_inc : '0;
        unique case (state_q)
          StAcquire: if (reach) begin
            state_d = StTrack;
            lcnt_d  = '0;
          end
          StTrack: if (upd_to_q) begin
            state_d = StAcquire;
            lcnt_d  = '0;
          end else if (reach) begin
            state_d = StLocked;
            lcnt_d  = '0;
          end
          StLocked: begin
            lcnt_d = '0;
            if (upd_to_q) state_d = StAcquire;
            else if (!in_tol) state_d = StTrack;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      ref_sync_q <= '0;
      fb_sync_q  <= '0;
      ref_pls_q  <= 1'b0;
      fb_pls_q   <= 1'b0;
      busy_q     <= 1'b0;
      ref_lead_q <= 1'b0;
      cnt_q      <= '0;
      error_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      upd_q      <= 1'b0;
      upd_err_q  <= '0;
      upd_to_q   <= 1'b0;
      integ_q    <= '0;
      freq_q     <= CTRL_WIDTH'(BIAS);
      lcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      ref_sync_q <= {ref_sync_q[1:0], ref_clk_i};
      fb_sync_q  <= {fb_sync_q[1:0], fb_clk_i};
      ref_pls_q  <= ref_sync_q[1] & ~ref_sync_q[2];
      fb_pls_q   <= fb_sync_q[1] & ~fb_sync_q[2];
      busy_q     <= busy_d;
      ref_lead_q <= ref_lead_d;
      cnt_q      <= cnt_d;
      if (emit) error_q <= emit_err;
      valid_q    <= emit;
      timeout_q  <= emit_to;
      // Snapshot the sample so a back-to-back emit cannot disturb the freq update.
      upd_q      <= valid_q && run;
      if (valid_q) begin
        upd_err_q <= error_q;
        upd_to_q  <= timeout_q;
      end
      integ_q    <= integ_d;
      freq_q     <= freq_d;
      lcnt_q     <= lcnt_d;
    end
  end

  assign freq_sel_o  = freq_q;
  assign error_o     = error_q;
  assign err_valid_o = valid_q;
  assign locked_o    = (state_q == StLocked);
  assign state_o     = state_q;

endmodule
